// File: rtl/image_readback_controller.sv
// Streams a frame buffer out over UART one byte per host `ACK, retransmitting on any other reply.
// Optional trailing XOR checksum byte is enabled by defining IMAGE_READBACK_CHECKSUM_EN.
`ifndef ACK
`define ACK 8'h06
`endif

module image_readback_controller #(
    parameter int IMAGE_BUF_X = 320,
    parameter int IMAGE_BUF_Y = 240
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_ready,
    input  logic        tx_busy,
    output logic [7:0]  tx_data,
    output logic        tx_ready,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [7:0]  mem_out,
    output logic        streaming_ended
);
    localparam int unsigned IMAGE_BUF_SIZE = IMAGE_BUF_X * IMAGE_BUF_Y * 2;
    localparam logic [31:0] LAST_ADDR      = 32'(IMAGE_BUF_SIZE - 1);

    typedef enum logic [2:0] {
        IDLE,
        MEM_REQ,
        TX_WAIT,
        TX_SEND,
        ACK_WAIT,
`ifdef IMAGE_READBACK_CHECKSUM_EN
        CSUM_WAIT,
`endif
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [7:0]  byte_q, byte_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_ready_q, tx_ready_d;
    logic        mem_req_q, mem_req_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic        ended_q, ended_d;
`ifdef IMAGE_READBACK_CHECKSUM_EN
    logic [7:0]  csum_q, csum_d;
    logic        csum_phase_q, csum_phase_d;
`endif

    logic rx_ack;
    assign rx_ack = rx_ready && (rx_data == `ACK);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            byte_q       <= '0;
            tx_data_q    <= '0;
            tx_ready_q   <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            ended_q      <= 1'b0;
`ifdef IMAGE_READBACK_CHECKSUM_EN
            csum_q       <= '0;
            csum_phase_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            byte_q       <= byte_d;
            tx_data_q    <= tx_data_d;
            tx_ready_q   <= tx_ready_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            ended_q      <= ended_d;
`ifdef IMAGE_READBACK_CHECKSUM_EN
            csum_q       <= csum_d;
            csum_phase_q <= csum_phase_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        byte_d       = byte_q;
        tx_data_d    = tx_data_q;
        tx_ready_d   = 1'b0;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        ended_d      = 1'b0;
`ifdef IMAGE_READBACK_CHECKSUM_EN
        csum_d       = csum_q;
        csum_phase_d = csum_phase_q;
`endif
        case (state_q)
            IDLE: begin
                if (rx_ack) begin
                    cnt_d      = '0;
                    mem_req_d  = 1'b1;
                    mem_addr_d = '0;
                    state_d    = MEM_REQ;
`ifdef IMAGE_READBACK_CHECKSUM_EN
                    csum_d       = '0;
                    csum_phase_d = 1'b0;
`endif
                end
            end
            MEM_REQ: begin
                if (mem_ready) begin
                    byte_d    = mem_out;
                    mem_req_d = 1'b0;
                    state_d   = TX_WAIT;
                end
            end
            TX_WAIT: begin
                if (!tx_busy) begin
                    tx_ready_d = 1'b1;
                    tx_data_d  = byte_q;
                    state_d    = TX_SEND;
                end
            end
            TX_SEND: begin
                state_d = ACK_WAIT;
`ifdef IMAGE_READBACK_CHECKSUM_EN
                if (csum_phase_q) state_d = CSUM_WAIT;
`endif
            end
            ACK_WAIT: begin
                if (rx_ack) begin
`ifdef IMAGE_READBACK_CHECKSUM_EN
                    // Only the accepting `ACK folds the byte in, so retransmits never double-count.
                    csum_d = csum_q ^ byte_q;
`endif
                    if (cnt_q == LAST_ADDR) begin
`ifdef IMAGE_READBACK_CHECKSUM_EN
                        byte_d       = csum_q ^ byte_q;
                        csum_phase_d = 1'b1;
                        state_d      = TX_WAIT;
`else
                        ended_d = 1'b1;
                        state_d = DONE;
`endif
                    end else begin
                        cnt_d      = cnt_q + 32'd1;
                        mem_req_d  = 1'b1;
                        mem_addr_d = cnt_q + 32'd1;
                        state_d    = MEM_REQ;
                    end
                end else if (rx_ready) begin
                    state_d = TX_WAIT;
                end
            end
`ifdef IMAGE_READBACK_CHECKSUM_EN
            CSUM_WAIT: begin
                if (rx_ack) begin
                    ended_d = 1'b1;
                    state_d = DONE;
                end else if (rx_ready) begin
                    state_d = TX_WAIT;
                end
            end
`endif
            DONE: begin
                cnt_d   = '0;
                state_d = IDLE;
`ifdef IMAGE_READBACK_CHECKSUM_EN
                csum_phase_d = 1'b0;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    assign tx_data         = tx_data_q;
    assign tx_ready        = tx_ready_q;
    assign mem_req         = mem_req_q;
    assign mem_addr        = mem_addr_q;
    assign streaming_ended = ended_q;
endmodule

// File: tb/tb_image_readback_controller.sv
// Bench for image_readback_controller: host/memory/UART models on a 4x3 frame with a queue-based reference.
module tb_image_readback_controller;
    localparam int X = 4;
    localparam int Y = 3;
    localparam int N = X * Y * 2;
`ifdef IMAGE_READBACK_CHECKSUM_EN
    localparam int TOTAL = N + 1;
`else
    localparam int TOTAL = N;
`endif
    localparam logic [7:0] ACK = 8'h06;

    logic        clk;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        tx_busy;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [7:0]  mem_out;
    logic        streaming_ended;

    image_readback_controller #(.IMAGE_BUF_X(X), .IMAGE_BUF_Y(Y)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_ready(rx_ready),
        .tx_busy(tx_busy), .tx_data(tx_data), .tx_ready(tx_ready),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
        .mem_out(mem_out), .streaming_ended(streaming_ended)
    );

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] mem [N];
    logic [7:0] txq [$];
    int         reqq [$];
    logic [7:0] expq [$];
    int         ended_cnt = 0;
    int         tx_cnt = 0;
    int         mreq_seen = 0;
    int         tx_base, req_base, ended_base;

    logic busy_dir, busy_rand, busy_rnd;
    assign tx_busy = busy_rand ? busy_rnd : busy_dir;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory with random 0..3 cycle latency; logs each granted address.
    initial begin
        int lat;
        lat = 0;
        mem_ready = 1'b0;
        mem_out   = 8'h00;
        forever begin
            @(negedge clk);
            if (mem_ready) mem_ready = 1'b0;
            else if (mem_req === 1'b1) begin
                if (lat == 0) begin
                    mem_ready = 1'b1;
                    mem_out   = (mem_addr < 32'(N)) ? mem[mem_addr] : 8'h00;
                    reqq.push_back(int'(mem_addr));
                    lat = int'($urandom_range(3));
                end else lat--;
            end
        end
    end

    initial begin
        busy_rnd = 1'b0;
        forever begin
            @(negedge clk);
            busy_rnd = ($urandom_range(2) == 0);
        end
    end

    always @(negedge clk) begin
        if (tx_ready === 1'b1) begin
            txq.push_back(tx_data);
            tx_cnt++;
        end
        if (streaming_ended === 1'b1) ended_cnt++;
        if (mem_req === 1'b1) mreq_seen++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] byte_at(input int i);
        logic [7:0] x;
        if (i < N) return mem[i];
        x = 8'h00;
        for (int k = 0; k < N; k++) x ^= mem[k];
        return x;
    endfunction

    function automatic logic [7:0] non_ack();
        logic [7:0] v;
        v = 8'($urandom);
        if (v == ACK) v = 8'h55;
        return v;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic wait_tx(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (tx_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic begin_frame();
        tx_base    = txq.size();
        req_base   = reqq.size();
        ended_base = ended_cnt;
        expq.delete();
        send_byte(ACK);
    endtask

    // Host side: accept bytes [from,to), optionally rejecting some once before acking.
    task automatic ack_bytes(input int from, input int to, input int nak_pct, input int nak_idx);
        bit ok, nak;
        logic [7:0] b;
        for (int i = from; i < to; i++) begin
            b   = byte_at(i);
            nak = (i == nak_idx) || (int'($urandom_range(99)) < nak_pct);
            wait_tx(ok);
            check("tx_timeout", 32'(ok), 32'd1);
            if (!ok) return;
            expq.push_back(b);
            if (nak) begin
                send_byte(non_ack());
                wait_tx(ok);
                check("retx_timeout", 32'(ok), 32'd1);
                if (!ok) return;
                expq.push_back(b);
            end
            if (i == TOTAL - 1) check("ended_early", 32'(ended_cnt - ended_base), 32'd0);
            send_byte(ACK);
        end
    endtask

    task automatic verify();
        int n;
        repeat (5) @(negedge clk);
        check("ended_count", 32'(ended_cnt - ended_base), 32'd1);
        check("tx_len", 32'(txq.size() - tx_base), 32'(expq.size()));
        n = txq.size() - tx_base;
        if (n > expq.size()) n = expq.size();
        for (int k = 0; k < n; k++) check("tx_byte", 32'(txq[tx_base + k]), 32'(expq[k]));
        check("req_len", 32'(reqq.size() - req_base), 32'(N));
        n = reqq.size() - req_base;
        if (n > N) n = N;
        for (int k = 0; k < n; k++) check("req_addr", 32'(reqq[req_base + k]), 32'(k));
    endtask

    initial begin
        bit ok;
        int seen, base_m, base_t;
        reset = 1'b0; rx_data = 8'h00; rx_ready = 1'b0;
        busy_dir = 1'b0; busy_rand = 1'b0;
        for (int i = 0; i < N; i++) mem[i] = 8'(i);

        #1;
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_tx_ready", 32'(tx_ready), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_ended", 32'(streaming_ended), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // Non-ACK traffic in IDLE must not start anything.
        base_m = mreq_seen; base_t = tx_cnt;
        repeat (3) send_byte(8'h55);
        repeat (3) send_byte(non_ack());
        repeat (10) @(negedge clk);
        check("idle_mem_req", 32'(mreq_seen - base_m), 32'd0);
        check("idle_tx", 32'(tx_cnt - base_t), 32'd0);
        check("idle_mem_addr", mem_addr, 32'd0);
        check("idle_tx_data", 32'(tx_data), 32'd0);

        // Clean frame, memory[i] = i.
        begin_frame();
        ack_bytes(0, TOTAL, 0, -1);
        verify();

        // Single rejection on byte 5.
        begin_frame();
        ack_bytes(0, TOTAL, 0, 5);
        verify();

        // Transmitter busy for 10 cycles after the first memory read.
        busy_dir = 1'b1;
        begin_frame();
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (mem_req === 1'b0) begin ok = 1'b1; break; end
        end
        check("busy_memrd_timeout", 32'(ok), 32'd1);
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (tx_ready === 1'b1) seen++;
        end
        check("busy_hold_tx", 32'(seen), 32'd0);
        busy_dir = 1'b0;
        @(negedge clk);
        check("busy_release_tx", 32'(tx_ready), 32'd1);
        check("busy_release_data", 32'(tx_data), 32'(mem[0]));
        @(negedge clk);
        check("busy_pulse_width", 32'(tx_ready), 32'd0);
        expq.push_back(byte_at(0));
        send_byte(ACK);
        ack_bytes(1, TOTAL, 0, -1);
        verify();

        // Asynchronous reset while waiting for the host at address 7.
        begin_frame();
        ack_bytes(0, 7, 0, -1);
        wait_tx(ok);
        check("pre_rst_timeout", 32'(ok), 32'd1);
        @(negedge clk);
        check("pre_rst_addr", mem_addr, 32'd7);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_tx_data", 32'(tx_data), 32'd0);
        check("mid_rst_tx_ready", 32'(tx_ready), 32'd0);
        check("mid_rst_mem_req", 32'(mem_req), 32'd0);
        check("mid_rst_mem_addr", mem_addr, 32'd0);
        check("mid_rst_ended", 32'(streaming_ended), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        begin_frame();
        ack_bytes(0, TOTAL, 0, -1);
        verify();

        // Random contents, random rejections, random transmitter stalls.
        busy_rand = 1'b1;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < N; i++) mem[i] = 8'($urandom);
            begin_frame();
            ack_bytes(0, TOTAL, 25, -1);
            verify();
        end
        busy_rand = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
